// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
//   IF-stage dynamic branch predictor. A direct-mapped table of 2-bit saturating
//   counters, indexed by pc[IDX_W+1:2], predicts conditional B-type branches.
//   The table is trained by the resolution coming back from ex. Saturating
//   statistics count resolved branches and mispredicts.
//
// Ports
//   clk                 clock, all state updates on posedge
//   rst                 synchronous reset, active-low
//   pc_i, inst_i        instruction currently in IF
//   prdt_taken_o        prediction for pc_i (combinational)
//   prdt_target_o       pc_i + B-immediate for branches, else 0
//   upd_valid_i         ex holds a resolved conditional branch
//   upd_pc_i            pc of that branch
//   upd_prdt_taken_i    prediction that was made for it
//   upd_flush_i         ex flushed it (mispredicted)
//   stat_branches_o     saturating resolved-branch count
//   stat_mispredicts_o  saturating mispredict count
module branch_predictor_bht #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        prdt_taken_o,
  output logic [31:0] prdt_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_prdt_taken_i,
  input  logic        upd_flush_i,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispredicts_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       bht_q [DEPTH];
  logic [31:0]      stat_branches_q;
  logic [31:0]      stat_mispredicts_q;

  logic             is_br;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      b_imm;
  logic             act_taken;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_nxt;

  assign is_br  = (inst_i[6:0] == 7'b1100011);
  assign rd_idx = pc_i[IDX_W+1:2];
  assign wr_idx = upd_pc_i[IDX_W+1:2];
  assign b_imm  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                   inst_i[11:8], 1'b0};

  // Outputs are forced quiet while reset is held so downstream stages never
  // see a prediction from a table that is being reinitialised.
  always_comb begin
    prdt_taken_o  = 1'b0;
    prdt_target_o = 32'h0;
    if (rst && is_br) begin
      prdt_taken_o  = bht_q[rd_idx][1];
      prdt_target_o = pc_i + b_imm;
    end
  end

  // ex flushes exactly when prediction and outcome differ.
  assign act_taken = upd_prdt_taken_i ^ upd_flush_i;
  assign cnt_cur   = bht_q[wr_idx];

  always_comb begin
    cnt_nxt = cnt_cur;
    if (act_taken) begin
      if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'd1;
    end
  end

  // The read port above sees the registered value, so a same-cycle update
  // to the entry being predicted only becomes visible next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= CNT_INIT;
      stat_branches_q    <= 32'h0;
      stat_mispredicts_q <= 32'h0;
    end else if (upd_valid_i) begin
      bht_q[wr_idx] <= cnt_nxt;
      if (stat_branches_q != 32'hFFFF_FFFF)
        stat_branches_q <= stat_branches_q + 32'd1;
      if (upd_flush_i && (stat_mispredicts_q != 32'hFFFF_FFFF))
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches_o    = stat_branches_q;
  assign stat_mispredicts_o = stat_mispredicts_q;

  // Bits not involved in indexing or immediate extraction.
  logic unused_bits;
  assign unused_bits = ^{inst_i[24:12], upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

endmodule
